// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU fetch/PC control path.
//   PCSRC_*          : encodings of the core's resolved next-PC selector
//   fetch_state_e    : state encoding of the fetch sequencer
//   RESET_PC_DEFAULT : default reset PC (word-aligned)
//   is_word_aligned  : helper used to qualify register jump targets
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BEQ = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_REQ   = 2'b01,
        S_ISSUE = 2'b10,
        S_HALT  = 2'b11
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : cpu_ctrl_pkg

// File: rtl/pc_next_calc.sv
// ----------------------------------------------------------------------------
// pc_next_calc
// Purely combinational next-PC selection.
//   i_pc       : current PC
//   i_pc_src   : selector (seq / beq / jr / j)
//   i_zero     : ALU zero flag, only meaningful for beq
//   i_imm      : sign-extended branch offset in words
//   i_jpc      : precomputed jump target
//   i_rd1      : register jump target
//   o_next_pc  : selected next PC (all arithmetic wraps modulo 2^32)
//   o_misalign : jr target is not word-aligned
// ----------------------------------------------------------------------------
module pc_next_calc
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_pc_src,
    input  logic        i_zero,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_jpc,
    input  logic [31:0] i_rd1,
    output logic [31:0] o_next_pc,
    output logic        o_misalign
);

    logic        [31:0] w_pc4;
    logic signed [31:0] w_br_off;
    logic        [31:0] w_br_tgt;

    assign w_pc4    = i_pc + 32'd4;
    // Word offset to byte offset; bits shifted out of the top are dropped,
    // which is what modulo-2^32 wrap requires.
    assign w_br_off = $signed({i_imm[29:0], 2'b00});
    assign w_br_tgt = w_pc4 + $unsigned(w_br_off);

    always_comb begin
        o_next_pc  = w_pc4;
        o_misalign = 1'b0;
        unique case (i_pc_src)
            PCSRC_SEQ: o_next_pc = w_pc4;
            PCSRC_BEQ: o_next_pc = i_zero ? w_br_tgt : w_pc4;
            PCSRC_JR: begin
                o_next_pc  = i_rd1;
                o_misalign = !is_word_aligned(i_rd1);
            end
            PCSRC_J:   o_next_pc = i_jpc;
            default:   o_next_pc = w_pc4;
        endcase
    end

endmodule : pc_next_calc

// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
// Owns the PC, fetches instructions over a req/ack handshake, presents them
// to the core and commits the core's resolved next PC on acceptance.
//   clk, rst         : clock, synchronous active-high reset
//   imem_req/addr    : fetch request and address (addr = pc)
//   imem_ack/rdata   : memory response, rdata valid when ack=1
//   instr_valid      : instr/pc_out hold an instruction awaiting acceptance
//   instr, pc_out    : fetched word and its PC
//   instr_accept     : core consumes instr; pc_src/zero/imm/jpc/rd1 valid
//   halted           : sticky, set on a misaligned jr target
//   inst_count       : accepted-instruction counter, wraps modulo 2^32
// ----------------------------------------------------------------------------
module pc_fetch_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    input  logic        instr_accept,
    input  logic [1:0]  pc_src,
    input  logic        zero,
    input  logic [31:0] imm,
    input  logic [31:0] jpc,
    input  logic [31:0] rd1,
    output logic        halted,
    output logic [31:0] inst_count
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_req;
    logic        r_valid;
    logic        r_halted;
    logic [31:0] r_count;

    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic        w_fetch_done;
    logic        w_accept;

    pc_next_calc u_pc_next_calc (
        .i_pc       (r_pc),
        .i_pc_src   (pc_src),
        .i_zero     (zero),
        .i_imm      (imm),
        .i_jpc      (jpc),
        .i_rd1      (rd1),
        .o_next_pc  (w_next_pc),
        .o_misalign (w_misalign)
    );

    // Handshake inputs only count in the state that expects them.
    assign w_fetch_done = (r_state == S_REQ)   && imem_ack;
    assign w_accept     = (r_state == S_ISSUE) && instr_accept;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_BOOT:  w_state_nxt = S_REQ;
            S_REQ:   if (w_fetch_done) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_accept)     w_state_nxt = w_misalign ? S_HALT : S_REQ;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_BOOT;
            r_pc     <= RESET_PC;
            r_instr  <= 32'h0;
            r_pc_out <= RESET_PC;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_count  <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            // Handshake outputs are registered copies of the next state so
            // they are glitch-free and line up with the state they describe.
            r_req   <= (w_state_nxt == S_REQ);
            r_valid <= (w_state_nxt == S_ISSUE);

            if (w_fetch_done) begin
                r_instr  <= imem_rdata;
                r_pc_out <= r_pc;
            end

            if (w_accept) begin
                r_count <= r_count + 32'd1;
                // A misaligned jr leaves pc pointing at the faulting
                // instruction so it can be inspected after the halt.
                if (w_misalign) begin
                    r_halted <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign halted      = r_halted;
    assign inst_count  = r_count;

endmodule : pc_fetch_ctrl

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_accept = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic        zero = 1'b0;
    logic [31:0] imm = 32'h0;
    logic [31:0] jpc = 32'h0;
    logic [31:0] rd1 = 32'h0;
    logic        halted;
    logic [31:0] inst_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc_out       (pc_out),
        .instr_accept (instr_accept),
        .pc_src       (pc_src),
        .zero         (zero),
        .imm          (imm),
        .jpc          (jpc),
        .rd1          (rd1),
        .halted       (halted),
        .inst_count   (inst_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Two reset edges, release at a negedge; returns in the idle boot cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0;
        instr_accept = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for a request, check its address, hold the memory off
    // for 'delay' cycles, then return 'data' and check the presented word.
    task automatic fetch(input string tag, input logic [31:0] exp_addr,
                         input int delay, input logic [31:0] data);
        int n;
        logic held;
        n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, exp_addr);
        held = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            held &= imem_req;
        end
        if (delay > 0) chk({tag, "_req_held"}, {31'b0, held}, 32'd1);
        imem_ack = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack = 1'b0;
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, data);
        chk({tag, "_pc_out"}, pc_out, exp_addr);
    endtask

    task automatic accept(input logic [1:0] src, input logic z,
                          input logic [31:0] im, input logic [31:0] jp,
                          input logic [31:0] r1);
        instr_accept = 1'b1;
        pc_src = src;
        zero = z;
        imm = im;
        jpc = jp;
        rd1 = r1;
        @(negedge clk);
        instr_accept = 1'b0;
    endtask

    initial begin : main
        logic held_low;

        // Reset state and boot timing with ack tied high
        do_reset();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_count", inst_count, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_0000;
        @(negedge clk);
        chk("boot_req", {31'b0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("boot_valid", {31'b0, instr_valid}, 32'd1);
        chk("boot_instr", instr, 32'hDEAD_0000);
        imem_ack = 1'b0;

        // Sequential fetch with a slow memory
        do_reset();
        fetch("seq0", 32'h0, 3, 32'h1111_0000);
        accept(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        fetch("seq1", 32'h4, 3, 32'h1111_0004);
        accept(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        fetch("seq2", 32'h8, 3, 32'h1111_0008);
        accept(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("seq_count", inst_count, 32'd3);

        // beq taken backwards: 0x10 + 4 - 8 = 0x0C
        fetch("j10a", 32'hC, 0, 32'h2222_0000);
        accept(2'b11, 1'b0, 32'h0, 32'h10, 32'h0);
        fetch("beqpc", 32'h10, 0, 32'h2222_0010);
        accept(2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'h0);
        fetch("beq_t", 32'h0C, 0, 32'h2222_000C);
        // beq not taken: 0x14
        accept(2'b11, 1'b0, 32'h0, 32'h10, 32'h0);
        fetch("beqpc2", 32'h10, 0, 32'h2222_0010);
        accept(2'b01, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h0);
        fetch("beq_nt", 32'h14, 0, 32'h2222_0014);
        // beq wrap: 0xFFFFFFF4 + 0xC = 0x0
        accept(2'b11, 1'b0, 32'h0, 32'hFFFF_FFF0, 32'h0);
        fetch("beqpc3", 32'hFFFF_FFF0, 1, 32'h2222_FFF0);
        accept(2'b01, 1'b1, 32'h3, 32'h0, 32'h0);
        fetch("beq_wrap", 32'h0, 0, 32'h2222_0000);

        // jr and j
        accept(2'b10, 1'b0, 32'h0, 32'h0, 32'h400);
        fetch("jr", 32'h400, 0, 32'h3333_0400);
        accept(2'b11, 1'b0, 32'h0, 32'h0040_0020, 32'h0);
        fetch("j", 32'h0040_0020, 2, 32'h3333_0020);
        chk("count_j", inst_count, 32'd11);

        // Spurious ack in S_ISSUE must not disturb the held instruction
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("sp_ack_instr", instr, 32'h3333_0020);
        chk("sp_ack_valid", {31'b0, instr_valid}, 32'd1);

        // Spurious accept in S_REQ must not move pc or the counter
        accept(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("count_pre_sp", inst_count, 32'd12);
        accept(2'b11, 1'b0, 32'h0, 32'h0000_0100, 32'h0);
        chk("sp_acc_count", inst_count, 32'd12);
        fetch("sp_acc", 32'h0040_0024, 0, 32'h4444_0024);

        // Misaligned jr halts
        accept(2'b10, 1'b0, 32'h0, 32'h0, 32'h402);
        chk("mis_halted", {31'b0, halted}, 32'd1);
        chk("mis_valid", {31'b0, instr_valid}, 32'd0);
        chk("mis_count", inst_count, 32'd13);
        chk("mis_pc_out", pc_out, 32'h0040_0024);
        held_low = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_ack = (i % 3 == 0);
            @(negedge clk);
            held_low &= !imem_req;
        end
        imem_ack = 1'b0;
        chk("halt_req_low", {31'b0, held_low}, 32'd1);
        chk("halt_sticky", {31'b0, halted}, 32'd1);
        do_reset();
        chk("halt_rst", {31'b0, halted}, 32'd0);
        chk("halt_rst_count", inst_count, 32'd0);
        fetch("restart", 32'h0, 0, 32'h5555_0000);

        // Reset while waiting in S_REQ
        accept(2'b11, 1'b0, 32'h0, 32'h0000_0800, 32'h0);
        chk("midreq_req", {31'b0, imem_req}, 32'd1);
        chk("midreq_addr", imem_addr, 32'h800);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_count", inst_count, 32'd0);
        rst = 1'b0;
        fetch("midrst_restart", 32'h0, 0, 32'h6666_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_pc_fetch_ctrl

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencing controller for the program counter and instruction fetch in the 32-bit CPU.
- Owns the PC register and runs a request/acknowledge handshake with instruction memory.
- Presents each fetched instruction to the core, then waits for the core to accept it along with its resolved control (pc_src, zero, imm, jpc, rd1).
- Computes and commits the next PC, and halts on a misaligned jump-register target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address; equals pc while imem_req=1
imem_ack  input  1  memory has valid data on imem_rdata this cycle
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instr/pc_out hold a fetched instruction awaiting acceptance
instr  output  32  registered instruction word
pc_out  output  32  PC of the instruction on instr
instr_accept  input  1  core consumes instr; control inputs below are valid this cycle
pc_src  input  2  00 sequential, 01 beq, 10 jr, 11 j
zero  input  1  ALU zero flag; used only when pc_src=01
imm  input  32  sign-extended branch offset, in words
jpc  input  32  precomputed jump target
rd1  input  32  register jump target
halted  output  1  sticky; set on misaligned jr target
inst_count  output  32  number of accepted instructions; wraps modulo 2^32

Behaviour:
- Reset (rst=1 at a clock edge) sets the following, regardless of the current state or any in-flight handshake:
  - pc=RESET_PC, state=S_BOOT
  - imem_req=0, instr_valid=0, instr=0
  - halted=0, inst_count=0
- States: S_BOOT, S_REQ, S_ISSUE, S_HALT.
- S_BOOT: unconditionally goes to S_REQ on the next cycle. This gives one idle cycle after reset.
- S_REQ:
  - imem_req=1 and imem_addr=pc. imem_req is registered and stays high until imem_ack is sampled high.
  - On imem_ack=1: instr<=imem_rdata, pc_out<=pc, instr_valid<=1, imem_req<=0, go to S_ISSUE.
- S_ISSUE:
  - instr_valid=1 is held, and instr and pc_out are stable, until instr_accept=1.
  - On accept, with pc4=pc+4, next_pc is:
    - 00: pc4
    - 01: pc4+(imm<<2) if zero=1, else pc4
    - 10: rd1
    - 11: jpc
  - All sums are 32-bit and wrap modulo 2^32.
  - On accept: pc<=next_pc, instr_valid<=0, inst_count<=inst_count+1, go to S_REQ.
- Misaligned jump target (pc_src=10 and rd1[1:0]!=0 on accept):
  - pc is unchanged, instr_valid<=0, halted<=1, inst_count still increments.
  - Go to S_HALT. S_HALT is left only by rst; imem_req stays 0.
- imem_ack outside S_REQ is ignored. instr_accept outside S_ISSUE is ignored.
- Timing: minimum latency is accept at cycle N, imem_req at N+1, ack at N+1, instr_valid at N+2. Peak throughput is one instruction per 2 cycles.
- pc_src=11 does not check jpc alignment; jpc is aligned by construction.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - PCSRC_SEQ=2'b00, PCSRC_BEQ=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11
  - the fetch-state encoding (S_BOOT, S_REQ, S_ISSUE, S_HALT)
  - the RESET_PC default
- One combinational sub-module, pc_next_calc, computes next_pc and the misalign flag from pc, pc_src, zero, imm, jpc and rd1. The FSM and all registers stay in pc_fetch_ctrl.

Test Plan:
- Reset/boot: rst high for 2 cycles then release, ack tied high -> imem_req=1 with imem_addr=0x0 on the 2nd cycle after release; instr_valid=1 one cycle later.
- Sequential with delayed memory: ack 3 cycles after req, accept with pc_src=00 -> addresses 0x0, 0x4, 0x8; imem_req held high throughout each wait; inst_count=3 after three accepts.
- beq: pc=0x10.
  - pc_src=01, zero=1, imm=0xFFFFFFFE -> next imem_addr=0x0C.
  - Same with zero=0 -> 0x14.
  - imm=0x3 at pc=0xFFFFFFF0 with zero=1 -> wraps to 0x00000000.
- jr/j: pc_src=10, rd1=0x400 -> imem_addr=0x400. pc_src=11, jpc=0x0040_0020 -> 0x0040_0020.
- Misaligned jr: rd1=0x402 on accept -> halted=1 next cycle; imem_req stays 0 for 20 cycles; pc unchanged; inst_count incremented; rst clears halted and restarts at RESET_PC.
- Reset mid-operation and spurious handshakes:
  - rst asserted in S_REQ while ack=0 -> imem_req=0 next cycle, restart from RESET_PC.
  - Spurious ack in S_ISSUE -> instr unchanged.
  - Spurious accept in S_REQ -> pc and inst_count unchanged.
